// File: rtl/adc_spi_responder_if.sv
// SPI link between an initiator and adc_spi_responder.
// Mode 0: sck idles low, data is sampled on the rising edge and shifted on
// the falling edge. cs_n is active-low framing.
interface adc_spi_responder_if;
    logic sck;
    logic cs_n;
    logic sdi;
    logic sdo;

    modport master (output sck, output cs_n, output sdi, input sdo);
    modport slave  (input sck, input cs_n, input sdi, output sdo);
endinterface

// File: rtl/adc_spi_responder.sv
// adc_spi_responder: SPI target that behaves like a 2-channel, 12-bit ADC.
// Command on sdi: start bit (leading zeros skipped), SGL, ODD, MSBF.
// Response on sdo: one null bit, then B11..B0, then (optionally) B1..B11.
// Optional LSB-first tail is built only when ADC_LSBF_EN is defined.
//
// Handshake: cmd_valid is a single-clk strobe with no back-pressure; it fires
// when MSBF is sampled, and cmd_sgl/cmd_odd hold the decoded command from
// that point until the next command overwrites them.
module adc_spi_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    adc_spi_responder_if.slave  spi,
    input  logic [11:0]         sample_ch0,
    input  logic [11:0]         sample_ch1,
    output logic                busy,
    output logic                cmd_valid,
    output logic                cmd_sgl,
    output logic                cmd_odd,
    output logic [3:0]          dbg_state
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_START = 4'd1,
        S_SGL   = 4'd2,
        S_ODD   = 4'd3,
        S_MSBF  = 4'd4,
        S_NULL  = 4'd5,
        S_DATA  = 4'd6,
`ifdef ADC_LSBF_EN
        S_LSBF  = 4'd7,
`endif
        S_DONE  = 4'd8
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sdi_sync;
    logic                   sck_prev;
    logic                   sck_s;
    logic                   cs_s;
    logic                   sdi_s;
    logic                   rise;
    logic                   fall;
    logic                   armed;
    logic                   sdo_q;
    logic [3:0]             bit_cnt;
    logic [11:0]            result;
    logic [12:0]            diff;
    logic [11:0]            next_result;
`ifdef ADC_LSBF_EN
    logic                   msbf_q;
`endif

    assign sck_s     = sck_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sdi_s     = sdi_sync[SYNC_STAGES-1];
    // Edges come from one synced history bit, so a rise and a fall can never
    // both be seen in the same clk.
    assign rise      = sck_s & ~sck_prev;
    assign fall      = ~sck_s & sck_prev;
    assign spi.sdo   = sdo_q;
    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

    // Bring the asynchronous SPI inputs into the clk domain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sck_sync <= '0;
            cs_sync  <= '0;
            sdi_sync <= '0;
            sck_prev <= 1'b0;
        end else begin
            sck_sync <= (sck_sync << 1) | SYNC_STAGES'(spi.sck);
            cs_sync  <= (cs_sync << 1)  | SYNC_STAGES'(spi.cs_n);
            sdi_sync <= (sdi_sync << 1) | SYNC_STAGES'(spi.sdi);
            sck_prev <= sck_s;
        end
    end

    // Conversion result for the command currently held in cmd_sgl/cmd_odd;
    // differential results are computed 13-bit and clamped at zero.
    always_comb begin
        diff        = 13'd0;
        next_result = 12'd0;
        if (cmd_sgl) begin
            next_result = cmd_odd ? sample_ch1 : sample_ch0;
        end else begin
            diff = cmd_odd ? ({1'b0, sample_ch1} - {1'b0, sample_ch0})
                           : ({1'b0, sample_ch0} - {1'b0, sample_ch1});
            next_result = diff[12] ? 12'd0 : diff[11:0];
        end
    end

    // Command decode and response shifter. armed is set only after cs_n has
    // been seen high, so a reset in mid-frame waits for a fresh cs_n frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            sdo_q     <= 1'b0;
            cmd_valid <= 1'b0;
            cmd_sgl   <= 1'b0;
            cmd_odd   <= 1'b0;
            bit_cnt   <= 4'd0;
            result    <= 12'd0;
            armed     <= 1'b0;
`ifdef ADC_LSBF_EN
            msbf_q    <= 1'b0;
`endif
        end else begin
            cmd_valid <= 1'b0;
            if (cs_s) begin
                state   <= S_IDLE;
                sdo_q   <= 1'b0;
                bit_cnt <= 4'd0;
                armed   <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        // sck edges seen here (including one coinciding
                        // with the cs_n fall) are deliberately ignored.
                        if (armed) state <= S_START;
                    end
                    S_START: begin
                        if (rise && sdi_s) state <= S_SGL;
                    end
                    S_SGL: begin
                        if (rise) begin
                            cmd_sgl <= sdi_s;
                            state   <= S_ODD;
                        end
                    end
                    S_ODD: begin
                        if (rise) begin
                            cmd_odd <= sdi_s;
                            state   <= S_MSBF;
                        end
                    end
                    S_MSBF: begin
                        if (rise) begin
`ifdef ADC_LSBF_EN
                            msbf_q    <= sdi_s;
`endif
                            result    <= next_result;
                            cmd_valid <= 1'b1;
                            state     <= S_NULL;
                        end
                    end
                    S_NULL: begin
                        if (fall) begin
                            sdo_q   <= 1'b0;
                            bit_cnt <= 4'd11;
                            state   <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (fall) begin
                            sdo_q <= result[bit_cnt];
                            if (bit_cnt == 4'd0) begin
`ifdef ADC_LSBF_EN
                                if (!msbf_q) begin
                                    bit_cnt <= 4'd1;
                                    state   <= S_LSBF;
                                end else begin
                                    state   <= S_DONE;
                                end
`else
                                state <= S_DONE;
`endif
                            end else begin
                                bit_cnt <= bit_cnt - 4'd1;
                            end
                        end
                    end
`ifdef ADC_LSBF_EN
                    S_LSBF: begin
                        if (fall) begin
                            sdo_q <= result[bit_cnt];
                            if (bit_cnt == 4'd11) state <= S_DONE;
                            else                  bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
`endif
                    S_DONE: begin
                        if (fall) sdo_q <= 1'b0;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Testbench for adc_spi_responder: an SPI initiator model drives command
// frames; the expected sdo stream comes from an arithmetic model of the ADC.
module tb_adc_spi_responder;

    localparam int SYNC_STAGES = 2;
    localparam int H           = 4;   // clk cycles per sck phase segment
    localparam int NTAIL       = 25;  // sck cycles clocked after the MSBF bit
`ifdef ADC_LSBF_EN
    localparam bit LSBF_EN = 1'b1;
`else
    localparam bit LSBF_EN = 1'b0;
`endif

    typedef struct {
        int          lead;
        logic        sgl;
        logic        odd;
        logic        msbf;
        logic [11:0] c0;
        logic [11:0] c1;
    } frame_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] sample_ch0;
    logic [11:0] sample_ch1;
    logic        busy;
    logic        cmd_valid;
    logic        cmd_sgl;
    logic        cmd_odd;
    logic [3:0]  dbg_state;

    int          errors    = 0;
    int          checks    = 0;
    int          valid_cnt = 0;
    logic [0:0]  exp_q[$];
    logic [0:0]  got_q[$];

    adc_spi_responder_if spi_if ();

    adc_spi_responder #(.SYNC_STAGES(SYNC_STAGES)) dut (
        .clk        (clk),
        .reset      (reset),
        .spi        (spi_if),
        .sample_ch0 (sample_ch0),
        .sample_ch1 (sample_ch1),
        .busy       (busy),
        .cmd_valid  (cmd_valid),
        .cmd_sgl    (cmd_sgl),
        .cmd_odd    (cmd_odd),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // count cmd_valid pulses, sampled away from the active edge
    always @(negedge clk) begin
        if (cmd_valid === 1'b1) valid_cnt <= valid_cnt + 1;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation still running at %0t, limit 600000", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [11:0] model_result(logic sgl, logic odd,
                                                 logic [11:0] c0, logic [11:0] c1);
        int d;
        if (sgl) return odd ? c1 : c0;
        d = odd ? (int'(c1) - int'(c0)) : (int'(c0) - int'(c1));
        if (d < 0) return 12'd0;
        return 12'(d);
    endfunction

    // Expected sdo seen after each sck fall: zero through the command bits
    // and null bit, then MSB-first word, optional LSB-first tail, zeros.
    task automatic build_exp(input frame_t f, input int nbits);
        logic [11:0] r;
        r = model_result(f.sgl, f.odd, f.c0, f.c1);
        exp_q.delete();
        for (int i = 0; i < f.lead + 4; i++) exp_q.push_back(1'b0);
        for (int i = 0; i < nbits; i++) begin
            if (i < 12)                               exp_q.push_back(r[11 - i]);
            else if (LSBF_EN && !f.msbf && i < 23)    exp_q.push_back(r[i - 11]);
            else                                      exp_q.push_back(1'b0);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic sck_cycle(input logic d, output logic q);
        spi_if.sdi = d;
        repeat (H) @(negedge clk);
        spi_if.sck = 1'b1;
        repeat (H) @(negedge clk);
        spi_if.sck = 1'b0;
        repeat (H) @(negedge clk);
        q = spi_if.sdo;
    endtask

    // Samples are scrambled after the MSBF bit so the frame must rely on the
    // word latched at that point.
    task automatic drive_frame(input frame_t f, input int nbits);
        logic q;
        got_q.delete();
        sample_ch0 = f.c0;
        sample_ch1 = f.c1;
        spi_if.cs_n = 1'b0;
        repeat (H) @(negedge clk);
        for (int i = 0; i < f.lead; i++) begin
            sck_cycle(1'b0, q); got_q.push_back(q);
        end
        sck_cycle(1'b1, q);   got_q.push_back(q);
        sck_cycle(f.sgl, q);  got_q.push_back(q);
        sck_cycle(f.odd, q);  got_q.push_back(q);
        sck_cycle(f.msbf, q); got_q.push_back(q);
        sample_ch0 = 12'($urandom);
        sample_ch1 = 12'($urandom);
        for (int i = 0; i < nbits; i++) begin
            sck_cycle(1'($urandom_range(0, 1)), q); got_q.push_back(q);
        end
    endtask

    task automatic end_frame();
        spi_if.cs_n = 1'b1;
        spi_if.sdi  = 1'b0;
        repeat (2 * H + SYNC_STAGES) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset       = 1'b0;
        spi_if.sck  = 1'b0;
        spi_if.cs_n = 1'b1;
        spi_if.sdi  = 1'b0;
        sample_ch0  = 12'd0;
        sample_ch1  = 12'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({spi_if.sdo, busy, cmd_valid, cmd_sgl, cmd_odd} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs got={sdo,busy,valid,sgl,odd}=%b exp=00000",
                     {spi_if.sdo, busy, cmd_valid, cmd_sgl, cmd_odd});
        end
        reset = 1'b1;
        repeat (2 * H) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset busy got=%b exp=0", busy);
        end
    endtask

    task automatic test_fixed_frames();
        frame_t tbl[5];
        string  nm[5];
        int     v0;
        tbl[0] = '{0, 1'b1, 1'b0, 1'b1, 12'hA5C, 12'h123}; nm[0] = "se_ch0_a5c";
        tbl[1] = '{2, 1'b1, 1'b1, 1'b1, 12'h7FF, 12'h800}; nm[1] = "se_ch1_lead0";
        tbl[2] = '{0, 1'b0, 1'b0, 1'b1, 12'h100, 12'h300}; nm[2] = "diff_clamp";
        tbl[3] = '{0, 1'b0, 1'b1, 1'b1, 12'h100, 12'h300}; nm[3] = "diff_pos";
        tbl[4] = '{0, 1'b1, 1'b0, 1'b0, 12'h001, 12'h000}; nm[4] = "lsbf_tail";
        for (int k = 0; k < 5; k++) begin
            v0 = valid_cnt;
            build_exp(tbl[k], NTAIL);
            drive_frame(tbl[k], NTAIL);
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL %s sdo[%0d] got=%b exp=%b", nm[k], i, got_q[i], exp_q[i]);
                end
            end
            checks++;
            if ({cmd_sgl, cmd_odd} !== {tbl[k].sgl, tbl[k].odd}) begin
                errors++;
                $display("FAIL %s cmd got sgl/odd=%b%b exp=%b%b", nm[k],
                         cmd_sgl, cmd_odd, tbl[k].sgl, tbl[k].odd);
            end
            checks++;
            if (valid_cnt - v0 !== 1) begin
                errors++;
                $display("FAIL %s cmd_valid pulses got=%0d exp=1", nm[k], valid_cnt - v0);
            end
            end_frame();
        end
    endtask

    task automatic test_random();
        frame_t f;
        int     v0;
        for (int k = 0; k < 6; k++) begin
            f.lead = int'($urandom_range(0, 3));
            f.sgl  = 1'($urandom_range(0, 1));
            f.odd  = 1'($urandom_range(0, 1));
            f.msbf = 1'($urandom_range(0, 1));
            f.c0   = 12'($urandom);
            f.c1   = 12'($urandom);
            v0 = valid_cnt;
            build_exp(f, NTAIL);
            drive_frame(f, NTAIL);
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL random%0d sdo[%0d] got=%b exp=%b", k, i, got_q[i], exp_q[i]);
                end
            end
            checks++;
            if (valid_cnt - v0 !== 1) begin
                errors++;
                $display("FAIL random%0d cmd_valid pulses got=%0d exp=1", k, valid_cnt - v0);
            end
            end_frame();
        end
    endtask

    task automatic test_cs_abort();
        frame_t f;
        int     v0;
        f = '{0, 1'b1, 1'b0, 1'b1, 12'($urandom), 12'h000};
        v0 = valid_cnt;
        build_exp(f, 5);
        drive_frame(f, 5);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL abort_partial sdo[%0d] got=%b exp=%b", i, got_q[i], exp_q[i]);
            end
        end
        spi_if.cs_n = 1'b1;
        for (int k = 0; k < SYNC_STAGES + 1; k++) begin
            @(negedge clk);
            if (busy === 1'b0) break;
        end
        checks++;
        if ({busy, spi_if.sdo} !== 2'b00) begin
            errors++;
            $display("FAIL abort_idle got busy=%b sdo=%b exp busy=0 sdo=0 within %0d clk",
                     busy, spi_if.sdo, SYNC_STAGES + 1);
        end
        end_frame();
        f = '{0, 1'b1, 1'b1, 1'b1, 12'h000, 12'hFFF};
        build_exp(f, NTAIL);
        drive_frame(f, NTAIL);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL abort_next sdo[%0d] got=%b exp=%b", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (valid_cnt - v0 !== 2) begin
            errors++;
            $display("FAIL abort cmd_valid pulses got=%0d exp=2", valid_cnt - v0);
        end
        end_frame();
    endtask

    task automatic test_reset_mid_frame();
        frame_t f;
        logic   q;
        int     v0;
        f = '{0, 1'b1, 1'b0, 1'b1, 12'hFFF, 12'h000};
        drive_frame(f, 3);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if ({spi_if.sdo, busy, cmd_valid, cmd_sgl, cmd_odd} !== 5'b0) begin
            errors++;
            $display("FAIL reset_mid outputs got={sdo,busy,valid,sgl,odd}=%b exp=00000",
                     {spi_if.sdo, busy, cmd_valid, cmd_sgl, cmd_odd});
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        v0 = valid_cnt;
        // cs_n is still low: a complete command must not be decoded
        for (int i = 0; i < 18; i++) begin
            sck_cycle((i < 4) ? 1'b1 : 1'($urandom_range(0, 1)), q);
            checks++;
            if ({busy, q} !== 2'b00) begin
                errors++;
                $display("FAIL reset_mid_hold cycle%0d got busy=%b sdo=%b exp 0 0", i, busy, q);
            end
        end
        checks++;
        if (valid_cnt !== v0) begin
            errors++;
            $display("FAIL reset_mid cmd_valid pulses got=%0d exp=0", valid_cnt - v0);
        end
        end_frame();
        f = '{1, 1'b1, 1'b0, 1'b1, 12'h5A3, 12'h000};
        build_exp(f, NTAIL);
        drive_frame(f, NTAIL);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL reset_mid_next sdo[%0d] got=%b exp=%b", i, got_q[i], exp_q[i]);
            end
        end
        end_frame();
    endtask

    initial begin
        test_reset();
        test_fixed_frames();
        test_random();
        test_cs_abort();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adc_spi_responder.md
ADC_SPI_RESPONDER -- requirements
Module: adc_spi_responder

Interface
REQ-001 Parameter SYNC_STAGES, default 2, synchronizer depth applied to sck, cs_n and sdi.
REQ-002 Port clk, input, 1, system clock; the clock frequency shall be at least 4x the sck frequency.
REQ-003 Port reset, input, 1, reset; asynchronous, active-low.
REQ-004 Port sck, input, 1, SPI serial clock from the initiator; idles low (mode 0).
REQ-005 Port cs_n, input, 1, chip enable from the initiator; active-low, high when idle.
REQ-006 Port sdi, input, 1, command bits from the initiator.
REQ-007 Port sample_ch0, input, 12, channel-0 conversion value.
REQ-008 Port sample_ch1, input, 12, channel-1 conversion value.
REQ-009 Port sdo, output, 1, serial response to the initiator.
REQ-010 Port busy, output, 1, high while in any state other than IDLE.
REQ-011 Port cmd_valid, output, 1, one-clk pulse when a complete command has been decoded.
REQ-012 Port cmd_sgl, output, 1, SGL bit of the last command; cmd_odd, output, 1, ODD/channel bit of the last command.

Function
REQ-013 Synchronization: sck, cs_n and sdi shall each pass through SYNC_STAGES flops; a rise is detected from the synced sck history, and likewise a fall.
REQ-014 Sampling and driving: all sdi sampling shall occur on a detected sck rise; sdo shall change only on a detected sck fall, registered one clk after detection.
REQ-015 States: IDLE, START, SGL, ODD, MSBF, NULL, DATA, LSBF, DONE.
REQ-016 IDLE -> START on synced cs_n low.
REQ-017 START: on each rise, sdi=0 keeps START (leading zeros ignored); sdi=1 moves to SGL.
REQ-018 SGL: on a rise, capture sdi to cmd_sgl and move to ODD.
REQ-019 ODD: on a rise, capture sdi to cmd_odd and move to MSBF.
REQ-020 MSBF: on a rise, capture the msbf bit, latch the 12-bit result word, pulse cmd_valid, and move to NULL.
REQ-021 NULL: on the next fall, drive sdo=0, load bit counter 11, and move to DATA.
REQ-022 DATA: each fall drives result[counter] and decrements the counter; after B0 is driven, msbf=0 goes to LSBF with counter 1, otherwise DONE.
REQ-023 LSBF: each fall drives result[counter] ascending B1..B11; after B11 is driven, go to DONE.
REQ-024 DONE: sdo shall be 0 on every subsequent fall; remain in DONE until cs_n rises.
REQ-025 Result word, SGL=1: ODD=0 gives sample_ch0; ODD=1 gives sample_ch1.
REQ-026 Result word, SGL=0 (differential): ODD=0 gives ch0-ch1 and ODD=1 gives ch1-ch0, computed 13-bit and clamped to 0 if negative.
REQ-027 The result word shall be latched once, at the MSBF rise; sample changes afterwards shall not affect the frame.
REQ-028 Synced cs_n high in any state shall force IDLE within 1 clk, with sdo=0 and the counter cleared; no cmd_valid is issued for a partial command.
REQ-029 A rise and a fall can never be detected in the same clk; the sck edge that coincides with the cs_n falling edge shall be ignored.
REQ-030 sck rises in NULL, DATA, LSBF or DONE shall ignore sdi.

Reset
REQ-031 When reset is low: state=IDLE; sdo, busy, cmd_valid, cmd_sgl, cmd_odd = 0; counter, result word and synchronizers cleared.
REQ-032 Reset assertion mid-frame shall abort the frame immediately; after release the block waits for cs_n high-then-low before decoding a new command.

Configuration
REQ-033 Macro ADC_LSBF_EN defined: LSBF state and the msbf=0 LSB-first tail are implemented per REQ-022/023.
REQ-034 Macro ADC_LSBF_EN undefined: no LSBF state; DATA always goes to DONE after B0, and msbf is captured but ignored.

Verification
REQ-035 SGL=1, ODD=0, MSBF=1, ch0=0xA5C -> cmd_valid pulses once; sdo frame 0,1,0,1,0,0,1,0,1,1,1,0,0 then zeros.
REQ-036 SGL=1, ODD=1, ch1=0x800, with leading sdi=0,0 before the start bit -> zeros ignored; sdo=0 (null),1, then eleven 0s; cmd_odd=1.
REQ-037 SGL=0, ODD=0, ch0=0x100, ch1=0x300 -> result 0x000, all sdo bits 0; SGL=0, ODD=1 with the same samples -> 0x200.
REQ-038 With ADC_LSBF_EN, MSBF=0, ch0=0x001 -> MSB-first B11..B0 = 0x001, then B1..B11 all 0; without ADC_LSBF_EN -> zeros after B0.
REQ-039 cs_n raised after the 5th data bit, then a new full frame for ch1=0xFFF -> busy=0 within SYNC_STAGES+1 clk, sdo=0; second frame returns twelve 1s.
REQ-040 reset pulsed low mid-DATA -> all outputs 0 immediately; no output until cs_n cycles high-low.
